ram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port 32 x 64-bit data RAM. Port 0 serves the CPU load/store path; port 1 serves a loader/debug master. The block serialises accesses with round-robin fairness and range-checks every address. It drives the RAM's address, read_en, write_en and data_in, and captures the RAM's out into per-port read-data registers.

---
 rtl/ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 32 x 64 data RAM.
// Port 0 is the CPU load/store path, port 1 the loader/debug master.
module ram_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e              state_q;
  logic                last_q;
  logic                sel_q;
  logic                we_q;
  logic                inr_q;
  logic                ack0_q, ack1_q;
  logic                err0_q, err1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mdata_q;
  logic                mre_q, mwe_q;

  logic                gnt_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                inr_d;

  // Grant selection: a lone requester wins, a tie goes to the port
  // that was not granted last time.
  always_comb begin
    gnt_d   = 1'b0;
    if (req1 && (!req0 || !last_q))
      gnt_d = 1'b1;
    we_d    = gnt_d ? we1    : we0;
    addr_d  = gnt_d ? addr1  : addr0;
    wdata_d = gnt_d ? wdata1 : wdata0;
    inr_d   = addr_d < ADDR_W'(DEPTH);
  end

  // Sequencer: IDLE grants and presents the access, ACCESS captures
  // read data and raises ack, RESP drops ack and returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      inr_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      mre_q    <= 1'b0;
      mwe_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            sel_q   <= gnt_d;
            last_q  <= gnt_d;
            we_q    <= we_d;
            inr_q   <= inr_d;
            maddr_q <= addr_d;
            mdata_q <= wdata_d;
            mre_q   <= !we_d && inr_d;
            mwe_q   <= we_d && inr_d;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          maddr_q <= '0;
          mdata_q <= '0;
          mre_q   <= 1'b0;
          mwe_q   <= 1'b0;
          if (sel_q) begin
            ack1_q <= 1'b1;
            err1_q <= !inr_q;
            if (!we_q)
              rdata1_q <= inr_q ? mem_out : '0;
          end else begin
            ack0_q <= 1'b1;
            err0_q <= !inr_q;
            if (!we_q)
              rdata0_q <= inr_q ? mem_out : '0;
          end
          state_q <= RESP;
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          maddr_q <= '0;
          mdata_q <= '0;
          mre_q   <= 1'b0;
          mwe_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign mem_address  = maddr_q;
  assign mem_data_in  = mdata_q;
  assign mem_read_en  = mre_q;
  assign mem_write_en = mwe_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 32-word RAM model
// preloaded with word[i] = i*100.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [63:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [63:0] rdata0, rdata1;
  logic [63:0] mem_address, mem_data_in, mem_out;
  logic        mem_read_en, mem_write_en;
  logic        preload;
  logic [63:0] ram [32];

  int errs = 0;
  int checks = 0;
  logic [63:0] m_rd0 = 64'd0;
  logic [63:0] m_rd1 = 64'd0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
    .mem_out(mem_out)
  );

  assign mem_out = (mem_address < 64'd32) ? ram[mem_address[4:0]] : 64'd0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= 64'(i * 100);
    end else if (mem_write_en && mem_address < 64'd32) begin
      ram[mem_address[4:0]] <= mem_data_in;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input int p, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic ee,
                       input logic [63:0] er);
    int n;
    logic inr;
    inr = a < 64'd32;
    @(negedge clk);
    if (p == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    @(negedge clk);
    chk("rd_en", mem_read_en, !w && inr);
    chk("wr_en", mem_write_en, w && inr);
    chk("addr", mem_address, a);
    chk("ack_early", p ? ack1 : ack0, 1'b0);
    @(negedge clk);
    n = 0;
    while (!(p ? ack1 : ack0) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ack_lat", n, 0);
    chk("err", p ? err1 : err0, ee);
    chk("other_ack", p ? ack0 : ack1, 1'b0);
    if (!w) begin
      if (p == 0) m_rd0 = er;
      else m_rd1 = er;
    end
    chk("rdata0", rdata0, m_rd0);
    chk("rdata1", rdata1, m_rd1);
    chk("resp_en", {63'd0, mem_read_en | mem_write_en}, 64'd0);
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
    @(negedge clk);
    chk("ack_pulse", p ? ack1 : ack0, 1'b0);
    chk("idle_wr", mem_write_en, 1'b0);
    chk("idle_rd", mem_read_en, 1'b0);
  endtask

  initial begin
    int last, cnt;
    reset = 1'b1; preload = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {ack0, ack1, err0, err1}, 4'b0);
    chk("rst_rd0", rdata0, 0);
    chk("rst_rd1", rdata1, 0);
    chk("rst_en", {mem_read_en, mem_write_en}, 2'b0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);
    preload = 1'b0;
    reset = 1'b0;

    do_op(0, 1'b0, 64'd5, 64'd0, 1'b0, 64'd500);
    do_op(1, 1'b1, 64'd3, 64'hDEAD, 1'b0, 64'd0);
    chk("ram3", ram[3], 64'hDEAD);
    do_op(1, 1'b0, 64'd3, 64'd0, 1'b0, 64'hDEAD);

    do_op(0, 1'b0, 64'd40, 64'd0, 1'b1, 64'd0);
    do_op(0, 1'b1, 64'd32, 64'h1234, 1'b1, 64'd0);
    chk("ram31", ram[31], 64'd3100);

    // both ports requesting continuously after reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rd0 = 0; m_rd1 = 0;
    req0 = 1; we0 = 0; addr0 = 64'd1;
    req1 = 1; we1 = 0; addr1 = 64'd2;
    last = -100; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack0 && ack1) chk("two_acks", 1, 0);
      if (ack0 || ack1) begin
        if (cnt > 0) chk("ack_gap", i - last, 3);
        chk("rr_grant", {63'd0, ack1}, cnt % 2);
        if (ack1) chk("rr_rd1", rdata1, 64'd200);
        else chk("rr_rd0", rdata0, 64'd100);
        last = i;
        cnt++;
      end
    end
    chk("rr_count", cnt, 7);
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    m_rd0 = 64'd100; m_rd1 = 64'd200;

    // reset in the middle of an access
    do_op(0, 1'b0, 64'd5, 64'd0, 1'b0, 64'd500);
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 64'd7;
    @(negedge clk);
    chk("mid_rd_en", mem_read_en, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 0;
    m_rd0 = 0; m_rd1 = 0;
    chk("mid_ack", ack0, 1'b0);
    chk("mid_en", {mem_read_en, mem_write_en}, 2'b0);
    chk("mid_rd0", rdata0, 0);
    @(negedge clk);
    chk("mid_ack2", ack0, 1'b0);
    req0 = 1; we0 = 0; addr0 = 64'd9;
    req1 = 1; we1 = 0; addr1 = 64'd10;
    @(negedge clk);
    chk("tie_addr", mem_address, 64'd9);
    @(negedge clk);
    chk("tie_ack0", ack0, 1'b1);
    chk("tie_ack1", ack1, 1'b0);
    chk("tie_rd0", rdata0, 64'd900);
    m_rd0 = 64'd900;
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("tie_ack0_off", ack0, 1'b0);

    do_op(1, 1'b0, 64'd2, 64'd0, 1'b0, 64'd200);
    repeat (3) @(negedge clk);
    chk("final_en", {mem_read_en, mem_write_en, ack0, ack1}, 4'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
